// File: rtl/ps2_tank_input.sv
// PS/2 keyboard receiver and key decoder producing held direction, moving and shoot levels.
// Define WASD_EN to also steer with the W/A/S/D keys (they alias the arrow keys).
module ps2_tank_input #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 3
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] direct,
    output logic       moving,
    output logic       shoot,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);
    localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic                   fall_s;
    logic                   bit_s;

    state_t      state_r;
    logic [2:0]  bcnt_r;
    logic [7:0]  sr_r;
    logic        par_r;
    logic [16:0] to_cnt_r;
    logic [3:0]  held_r;
    logic        brk_r;
    logic        ext_r;

    logic        dir_hit_s;
    logic [1:0]  dir_code_s;
    logic        is_space_s;
    logic [3:0]  held_after_s;
    logic [1:0]  lowest_s;

    // Pin synchronisers, idling high so reset never fakes a falling edge
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            clk_sync_r  <= '1;
            data_sync_r <= '1;
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign fall_s = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    assign bit_s  = data_sync_r[SYNC_STAGES-1];

    // Classify the byte sitting in the shift register and precompute the break result
    always_comb begin
        dir_hit_s  = 1'b0;
        dir_code_s = 2'd0;
        is_space_s = 1'b0;
        if (ext_r) begin
            case (sr_r)
                8'h6B:   begin dir_hit_s = 1'b1; dir_code_s = 2'd0; end
                8'h74:   begin dir_hit_s = 1'b1; dir_code_s = 2'd1; end
                8'h75:   begin dir_hit_s = 1'b1; dir_code_s = 2'd2; end
                8'h72:   begin dir_hit_s = 1'b1; dir_code_s = 2'd3; end
                default: dir_hit_s = 1'b0;
            endcase
        end else begin
            case (sr_r)
                8'h29:   is_space_s = 1'b1;
`ifdef WASD_EN
                8'h1C:   begin dir_hit_s = 1'b1; dir_code_s = 2'd0; end
                8'h23:   begin dir_hit_s = 1'b1; dir_code_s = 2'd1; end
                8'h1D:   begin dir_hit_s = 1'b1; dir_code_s = 2'd2; end
                8'h1B:   begin dir_hit_s = 1'b1; dir_code_s = 2'd3; end
`endif
                default: is_space_s = 1'b0;
            endcase
        end
        held_after_s = held_r & ~(4'b0001 << dir_code_s);
        if (held_after_s[0]) begin
            lowest_s = 2'd0;
        end else if (held_after_s[1]) begin
            lowest_s = 2'd1;
        end else if (held_after_s[2]) begin
            lowest_s = 2'd2;
        end else begin
            lowest_s = 2'd3;
        end
    end

    // Frame FSM, timeout supervision and key decode with registered outputs
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            bcnt_r     <= 3'd0;
            sr_r       <= 8'd0;
            par_r      <= 1'b0;
            to_cnt_r   <= 17'd0;
            held_r     <= 4'd0;
            brk_r      <= 1'b0;
            ext_r      <= 1'b0;
            direct     <= 3'b001;
            moving     <= 1'b0;
            shoot      <= 1'b0;
            scan_code  <= 8'd0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            // A falling edge always beats a simultaneous timeout
            if (state_r == IDLE || fall_s) begin
                to_cnt_r <= 17'd0;
            end else if (to_cnt_r == TO_LAST) begin
                to_cnt_r  <= 17'd0;
                frame_err <= 1'b1;
                state_r   <= IDLE;
            end else begin
                to_cnt_r <= to_cnt_r + 17'd1;
            end
            if (fall_s) begin
                case (state_r)
                    IDLE: begin
                        bcnt_r  <= 3'd0;
                        state_r <= bit_s ? IDLE : DATA;
                    end
                    DATA: begin
                        sr_r   <= {bit_s, sr_r[7:1]};
                        bcnt_r <= bcnt_r + 3'd1;
                        if (bcnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_r   <= bit_s;
                        state_r <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        if (bit_s && odd_parity_ok({sr_r, par_r})) begin
                            scan_code  <= sr_r;
                            scan_valid <= 1'b1;
                            if (sr_r == 8'hF0) begin
                                brk_r <= 1'b1;
                            end else if (sr_r == 8'hE0) begin
                                ext_r <= 1'b1;
                            end else begin
                                brk_r <= 1'b0;
                                ext_r <= 1'b0;
                                if (is_space_s) begin
                                    shoot <= ~brk_r;
                                end
                                if (dir_hit_s && !brk_r) begin
                                    held_r[dir_code_s] <= 1'b1;
                                    direct             <= {1'b0, dir_code_s};
                                    moving             <= 1'b1;
                                end else if (dir_hit_s) begin
                                    held_r <= held_after_s;
                                    moving <= |held_after_s;
                                    if (direct == {1'b0, dir_code_s} && |held_after_s) begin
                                        direct <= {1'b0, lowest_s};
                                    end
                                end
                            end
                        end else begin
                            frame_err <= 1'b1;
                            brk_r     <= 1'b0;
                            ext_r     <= 1'b0;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_tank_input.sv
// Scoreboard bench for ps2_tank_input: a key-state model predicts every scan_valid/frame_err event.
module tb_ps2_tank_input;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       clk_100mhz = 1'b0;
    logic       rst        = 1'b1;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [2:0] direct;
    logic       moving;
    logic       shoot;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    ps2_tank_input #(.TIMEOUT_CYC(TO), .SYNC_STAGES(3)) dut (
        .clk_100mhz(clk_100mhz), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .direct(direct), .moving(moving), .shoot(shoot),
        .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        logic       err;
        logic [7:0] code;
        logic [2:0] dir;
        logic       mov;
        logic       sht;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0, fails = 0, sv_seen = 0, fe_seen = 0;

    // key model: set of held directions, pending prefixes, current direction, space level
    bit   m_held[4];
    bit   m_brk, m_ext, m_shoot;
    int   m_dir;

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int dir_of(bit ext, logic [7:0] b);
        if (ext) begin
            if (b == 8'h6B) return 0;
            if (b == 8'h74) return 1;
            if (b == 8'h75) return 2;
            if (b == 8'h72) return 3;
        end else begin
`ifdef WASD_EN
            if (b == 8'h1C) return 0;
            if (b == 8'h23) return 1;
            if (b == 8'h1D) return 2;
            if (b == 8'h1B) return 3;
`endif
        end
        return -1;
    endfunction

    function automatic bit any_held();
        return m_held[0] || m_held[1] || m_held[2] || m_held[3];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        m_brk = 0; m_ext = 0; m_shoot = 0; m_dir = 1;
    endtask

    task automatic push(bit err, logic [7:0] b);
        exp_t x;
        x.err = err; x.code = b; x.dir = 3'(m_dir); x.mov = any_held(); x.sht = m_shoot;
        q.push_back(x);
    endtask

    task automatic model_byte(logic [7:0] b);
        int d;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            d = dir_of(m_ext, b);
            if (d >= 0 && !m_brk) begin
                m_held[d] = 1;
                m_dir = d;
            end else if (d >= 0) begin
                m_held[d] = 0;
                if (m_dir == d) begin
                    for (int i = 0; i < 4; i++) if (m_held[i]) begin m_dir = i; break; end
                end
            end else if (!m_ext && b == 8'h29) m_shoot = !m_brk;
            m_brk = 0; m_ext = 0;
        end
        push(1'b0, b);
    endtask

    // Monitor: every output event must match the next queued expectation
    always @(negedge clk_100mhz) begin
        if (scan_valid === 1'b1 || frame_err === 1'b1) begin
            if (scan_valid) sv_seen++;
            if (frame_err) fe_seen++;
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_event: scan_valid=%0b frame_err=%0b code=%0h",
                         scan_valid, frame_err, scan_code);
            end else begin
                e = q.pop_front();
                check("event_kind", {7'd0, frame_err}, {7'd0, e.err});
                if (!e.err) begin
                    check("scan_code", scan_code, e.code);
                    check("direct", {5'd0, direct}, {5'd0, e.dir});
                    check("moving", {7'd0, moving}, {7'd0, e.mov});
                    check("shoot", {7'd0, shoot}, {7'd0, e.sht});
                end
            end
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk_100mhz);
        #2;
    endtask

    task automatic ps2_bit(logic v);
        ps2_data = v;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(logic [7:0] b, logic bad_par, logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send_key(logic [7:0] b);
        model_byte(b);
        send_raw(b, 1'b0, 1'b0);
    endtask

    task automatic send_bad(logic [7:0] b, logic bad_par, logic bad_stop);
        m_brk = 0; m_ext = 0;
        push(1'b1, 8'd0);
        send_raw(b, bad_par, bad_stop);
    endtask

    logic [7:0] pool[12] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72,
                             8'h29, 8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h00};

    initial begin
        int sv0, fe0;
        logic [7:0] b;
        model_reset();
        wait_cyc(5);
        check("rst_direct", {5'd0, direct}, 8'h01);
        check("rst_moving", {7'd0, moving}, 8'h00);
        check("rst_shoot", {7'd0, shoot}, 8'h00);
        check("rst_scan_code", scan_code, 8'h00);
        rst = 1'b0;
        wait_cyc(10);

        send_key(8'hE0); send_key(8'h75);
        check("t2_direct_up", {5'd0, direct}, 8'h02);
        check("t2_moving", {7'd0, moving}, 8'h01);
        send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
        check("t2_release_moving", {7'd0, moving}, 8'h00);
        check("t2_release_direct", {5'd0, direct}, 8'h02);

        send_key(8'hE0); send_key(8'h6B);
        check("t3_left", {5'd0, direct}, 8'h00);
        send_key(8'hE0); send_key(8'h72);
        check("t3_down", {5'd0, direct}, 8'h03);
        send_key(8'hE0); send_key(8'hF0); send_key(8'h72);
        check("t3_back_left", {5'd0, direct}, 8'h00);
        check("t3_moving", {7'd0, moving}, 8'h01);
        send_key(8'hE0); send_key(8'hF0); send_key(8'h6B);

        send_key(8'h29);
        check("t4_shoot_on", {7'd0, shoot}, 8'h01);
        send_key(8'hF0); send_key(8'h29);
        check("t4_shoot_off", {7'd0, shoot}, 8'h00);
        send_bad(8'h29, 1'b1, 1'b0);
        check("t4_bad_parity_shoot", {7'd0, shoot}, 8'h00);
        send_bad(8'h29, 1'b0, 1'b1);

        push(1'b1, 8'd0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        wait_cyc(TO * 11 / 10 + 100);
        send_key(8'h29);
        check("t5_after_timeout", {7'd0, shoot}, 8'h01);

        send_key(8'h1D);
`ifdef WASD_EN
        check("t6_wasd_direct", {5'd0, direct}, 8'h02);
        check("t6_wasd_moving", {7'd0, moving}, 8'h01);
`else
        check("t6_no_wasd_direct", {5'd0, direct}, 8'h00);
        check("t6_no_wasd_moving", {7'd0, moving}, 8'h00);
`endif
        send_key(8'hF0); send_key(8'h1D);

        for (int n = 0; n < 50; n++) begin
            b = pool[$urandom_range(0, 11)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) send_bad(b, 1'b1, 1'b0);
            else send_key(b);
        end

        send_key(8'hE0); send_key(8'h75); send_key(8'h29);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        #3 rst = 1'b1;
        #1;
        check("t1_direct", {5'd0, direct}, 8'h01);
        check("t1_moving", {7'd0, moving}, 8'h00);
        check("t1_shoot", {7'd0, shoot}, 8'h00);
        model_reset();
        ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cyc(10);
        sv0 = sv_seen; fe0 = fe_seen;
        #3 rst = 1'b0;
        wait_cyc(200);
        check("t1_no_scan_valid", 8'(sv_seen - sv0), 8'h00);
        check("t1_no_frame_err", 8'(fe_seen - fe0), 8'h00);
        send_key(8'h29);
        check("t1_clean_frame", {7'd0, shoot}, 8'h01);

        wait_cyc(50);
        check("queue_drained", 8'(q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
